waveform_freq_meter: RTL
========================

# waveform_freq_meter

Quadrature frequency meter for the receive side of the waveform generator path. It consumes the generator's 8-bit offset-binary sine and cosine samples and detects rising midscale crossings of the sine with hysteresis. It reports the period in samples and the rotation direction, which recovers the sign of the signed control word that produced the waveform. A lock flag indicates that consecutive measurements agree, so the controller/testbench loop can close on a measured value.

## Interface
Parameters:
- HYST, 8, hysteresis half-width in LSBs around midscale 128. Low threshold is 128-HYST; high threshold is 128+HYST. Legal range 1..64.
- CNT_W, 16, width of the sample counter and of period_out.
- TOL, 1, maximum |period - previous period|, in samples, for lock.

Ports:
- clk, input, 1, single clock; all logic on posedge.
- reset, input, 1, synchronous, active-low (reset==0 clears on the next posedge).
- sample_valid, input, 1, qualifies sin_in/cos_in this cycle.
- sin_in, input, 8, unsigned sine sample, midscale 128.
- cos_in, input, 8, unsigned cosine sample, midscale 128.
- period_out, output, CNT_W, last measured period in valid samples.
- dir_out, output, 1, 0 = positive rotation (cos_in >= 128 at the crossing), 1 = negative.
- meas_valid, output, 1, one-cycle pulse when period_out/dir_out update.
- locked, output, 1, level; measurements are stable.
- timeout, output, 1, one-cycle pulse when the counter saturates with no crossing.

## Operation
- Crossing FSM, advances only on sample_valid=1:
  - SEEK: wait for sin_in < 128-HYST, then go to ARMED.
  - ARMED: on sin_in >= 128+HYST, a crossing occurs; go to ABOVE.
  - ABOVE: on sin_in < 128-HYST, go to ARMED.
  - Samples between the thresholds never change state, so noise within ±HYST produces no crossings.
- Sample counter cnt (CNT_W bits): cleared to 0 on every crossing; incremented on each valid non-crossing sample. Period = cnt+1, which is the sample-index distance between crossings.
- first_seen flag: the first crossing after reset or timeout only clears cnt and sets first_seen. It produces no measurement.
- At each subsequent crossing:
  - period_out <= cnt+1.
  - dir_out <= (cos_in < 128).
  - meas_valid pulses.
- Lock:
  - The previous period and direction are held internally.
  - At each measurement, locked <= 1 when a previous measurement exists, |new - prev| <= TOL, and the direction is the same; otherwise locked <= 0.
  - The new values then become prev.
  - Lock therefore needs at least two measurements, i.e. three crossings.
- Timeout:
  - Triggered by a valid non-crossing sample while cnt == 2^CNT_W-1.
  - Effects: timeout pulses, locked <= 0, first_seen <= 0, the previous measurement is invalidated, cnt <= 0, FSM <= SEEK.
  - period_out and dir_out hold their last values.
- Arithmetic: threshold compares are unsigned 8-bit. The period difference is computed in CNT_W+1 bits signed before taking the absolute value; no wrap.

## Timing
- Reset values: period_out=0, dir_out=0, meas_valid=0, locked=0, timeout=0. FSM=SEEK, cnt=0, first_seen=0, previous measurement invalid.
- Reset mid-measurement discards everything; the next measurement needs two fresh crossings.
- Latency: a crossing sample accepted at posedge k drives period_out, dir_out, meas_valid and locked valid after posedge k+1 (one register stage). timeout has the same 1-cycle latency.
- sample_valid=0 cycles freeze the FSM and cnt. Outputs hold; pulses are 0.
- Crossing and saturation on the same sample: the crossing wins, with period = 2^CNT_W (cnt+1 computed at CNT_W+1 bits, then saturated to 2^CNT_W-1 on output).
- meas_valid and timeout are never high in the same cycle.
- Back-to-back crossings are impossible: at least one sample below the low threshold is needed between them. The minimum period is 2.

## Test plan
- 16-sample/cycle full-scale sine/cosine (generator, period=16, control=+8 equivalent), sample_valid=1 → meas_valid pulses every 16 cycles with period_out=16 and dir_out=0; locked=1 from the second measurement onward.
- Same waveform with the cosine negated (negative control) → period_out=16, dir_out=1, locked=1.
- sample_valid toggling 1/0 every cycle with the same 16-sample sequence → period_out=16 samples, meas_valid every 32 clocks.
- Sine held at 128±4 with HYST=8 for 70000 valid samples → no meas_valid; timeout pulses once 65536 samples after reset; locked=0.
- Period switched from 16 to 32 samples while locked:
  - First 32 measurement → period_out=32, locked=0.
  - Next measurement → locked=1.
  - Period 16→17 with TOL=1 keeps locked=1.
- reset driven to 0 for one cycle between crossings while locked:
  - All outputs become 0 after that posedge.
  - The first meas_valid comes only at the second crossing after release, and locked requires the third.

Source files
------------

// File: rtl/waveform_freq_meter.sv
// Quadrature frequency meter: measures the period between rising midscale crossings
// of an 8-bit offset-binary sine and recovers rotation direction from the cosine.
module waveform_freq_meter #(
    parameter int HYST  = 8,
    parameter int CNT_W = 16,
    parameter int TOL   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [7:0]       sin_in,
    input  logic [7:0]       cos_in,
    output logic [CNT_W-1:0] period_out,
    output logic             dir_out,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [7:0]       LO_TH   = 8'(128 - HYST);
    localparam logic [7:0]       HI_TH   = 8'(128 + HYST);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0]   TOL_W   = (CNT_W + 1)'(TOL);

    typedef enum logic [1:0] {
        SEEK,
        ARMED,
        ABOVE
    } state_t;

    state_t state, state_next;

    logic             valid_q;
    logic [7:0]       sin_q;
    logic             cos_neg_q;

    logic [CNT_W-1:0] cnt;
    logic             first_seen;
    logic [CNT_W-1:0] prev_period;
    logic             prev_dir;
    logic             prev_valid;

    logic                    below;
    logic                    above;
    logic                    crossing;
    logic                    saturate;
    logic [CNT_W:0]          period_raw;
    logic [CNT_W-1:0]        period_sat;
    logic signed [CNT_W:0]   period_diff;
    logic [CNT_W:0]          period_abs;
    logic                    lock_ok;

    // Input stage: everything downstream works on the registered sample.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            sin_q     <= 8'd0;
            cos_neg_q <= 1'b0;
        end else begin
            valid_q   <= sample_valid;
            sin_q     <= sin_in;
            cos_neg_q <= (cos_in < 8'd128);
        end
    end

    assign below    = (sin_q < LO_TH);
    assign above    = (sin_q >= HI_TH);
    assign crossing = valid_q && (state == ARMED) && above;
    assign saturate = valid_q && !crossing && (cnt == CNT_MAX);

    // Period is computed one bit wider so a crossing on a saturated count still reads 2^CNT_W.
    assign period_raw  = {1'b0, cnt} + 1'b1;
    assign period_sat  = period_raw[CNT_W] ? CNT_MAX : period_raw[CNT_W-1:0];
    assign period_diff = $signed({1'b0, period_sat}) - $signed({1'b0, prev_period});
    assign period_abs  = period_diff[CNT_W] ? $unsigned(-period_diff) : $unsigned(period_diff);
    assign lock_ok     = prev_valid && (period_abs <= TOL_W) && (cos_neg_q == prev_dir);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= SEEK;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (saturate) begin
            state_next = SEEK;
        end else if (valid_q) begin
            case (state)
                SEEK:    if (below) state_next = ARMED;
                ARMED:   if (above) state_next = ABOVE;
                ABOVE:   if (below) state_next = ARMED;
                default: state_next = SEEK;
            endcase
        end
    end

    // The first crossing after reset or timeout only starts the count; later ones measure.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt         <= '0;
            first_seen  <= 1'b0;
            prev_period <= '0;
            prev_dir    <= 1'b0;
            prev_valid  <= 1'b0;
            period_out  <= '0;
            dir_out     <= 1'b0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            if (crossing) begin
                cnt <= '0;
                if (!first_seen) begin
                    first_seen <= 1'b1;
                end else begin
                    period_out  <= period_sat;
                    dir_out     <= cos_neg_q;
                    meas_valid  <= 1'b1;
                    locked      <= lock_ok;
                    prev_period <= period_sat;
                    prev_dir    <= cos_neg_q;
                    prev_valid  <= 1'b1;
                end
            end else if (saturate) begin
                cnt        <= '0;
                timeout    <= 1'b1;
                locked     <= 1'b0;
                first_seen <= 1'b0;
                prev_valid <= 1'b0;
            end else if (valid_q) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
